// File: rtl/ws2812_tx.sv
// WS2812/WS2812B serial line encoder: GRB pixels in over valid/ready, NRZ pulse code out.
// Define WS_UNDERRUN_EN to time out a starved mid-frame gap and pulse underrun.
module ws2812_tx #(
  parameter int T0H_CYC  = 18,
  parameter int T1H_CYC  = 37,
  parameter int TBIT_CYC = 66,
  parameter int TRST_CYC = 15750
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CW = $clog2(TBIT_CYC);
  localparam int RW = $clog2(TRST_CYC);

  localparam logic [CW-1:0] T0H_C     = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H_CYC);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
  localparam logic [RW-1:0] TRST_LAST = RW'(TRST_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [23:0]   data_q, data_d;
  logic          last_q, last_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          load;
  logic          bit_end;

  assign bit_end = (cyc_q == TBIT_LAST);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_d     = last_q;
    bit_idx_d  = bit_idx_q;
    cyc_d      = cyc_q;
    cnt_d      = cnt_q;
    pix_ready  = 1'b0;
    frame_done = 1'b0;
    underrun   = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pix_ready = 1'b1;
        load      = pix_valid;
      end
      ST_SHIFT: begin
        if (bit_end) begin
          if (bit_idx_q != 5'd0) begin
            bit_idx_d = bit_idx_q - 5'd1;
            cyc_d     = '0;
          end else if (last_q) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else begin
            // Pixel boundary: the only SHIFT cycle that can take the next pixel
            pix_ready = 1'b1;
            if (pix_valid) begin
              load = 1'b1;
            end else begin
              state_d = ST_GAP;
              cnt_d   = '0;
            end
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_GAP: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          load = 1'b1;
`ifdef WS_UNDERRUN_EN
        end else if (cnt_q == TRST_LAST) begin
          // Line has been low long enough that the chain already latched a partial frame
          underrun = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_LATCH: begin
        if (cnt_q == TRST_LAST) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d   = ST_SHIFT;
      data_d    = pix_data;
      last_d    = pix_last;
      bit_idx_d = 5'd23;
      cyc_d     = '0;
    end

    if (!rst_n) begin
      pix_ready  = 1'b0;
      frame_done = 1'b0;
      underrun   = 1'b0;
    end
  end

  // Line level is computed from next state so dout is a clean flop output aligned with state_q
  assign dout_d = (state_d == ST_SHIFT) &&
                  (cyc_d < (data_d[bit_idx_d] ? T1H_C : T0H_C));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      last_q    <= last_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: pixel table plus hand-written reset, latch and gap sequences.
module tb_ws2812_tx;

  localparam int T0H  = 18;
  localparam int T1H  = 37;
  localparam int TBIT = 66;
  localparam int TRST = 15750;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_valid;
  logic        pix_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [23:0] data;
    logic        last;
    int          gap;   // cycles valid is withheld before this pixel is offered
    int          ones;  // hand-counted '1' bits in data
  } vec_t;

  vec_t vec[5];

  always #5 clk = ~clk;

  ws2812_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Entered at the negedge before the accepting posedge; leaves at the negedge of the pixel's last cycle.
  task automatic check_pixel(input logic [23:0] d, input logic lst, input int ones,
                             input logic nv, input logic [23:0] nd, input logic nl);
    int high_tot = 0;
    int ready_err = 0;
    int misc_err = 0;
    for (int k = 0; k < 24; k++) begin
      logic b;
      int hi = 0;
      int shape_ok = 1;
      int thr;
      b   = d[23-k];
      thr = b ? T1H : T0H;
      for (int c = 0; c < TBIT; c++) begin
        @(negedge clk);
        if (int'(dout) != ((c < thr) ? 1 : 0)) shape_ok = 0;
        if (dout) hi++;
        if (int'(pix_ready) != ((k == 23 && c == TBIT-1 && !lst) ? 1 : 0)) ready_err++;
        if (!busy || frame_done || underrun) misc_err++;
        if (k == 0 && c == 0) begin
          pix_valid = nv;
          if (nv) begin
            pix_data = nd;
            pix_last = nl;
          end
        end
      end
      high_tot += hi;
      check_int($sformatf("px%06h_bit%0d_high", d, 23-k), hi + (shape_ok != 0 ? 0 : 1000), thr);
    end
    check_int($sformatf("px%06h_high_total", d), high_tot, ones*T1H + (24-ones)*T0H);
    check_int($sformatf("px%06h_ready_errs", d), ready_err, 0);
    check_int($sformatf("px%06h_busy_flag_errs", d), misc_err, 0);
  endtask

  // Latch interval, then the first IDLE cycle.
  task automatic check_latch();
    int d_hi = 0, r_hi = 0, b_lo = 0, fd_cnt = 0, fd_pos = -1;
    for (int i = 0; i < TRST; i++) begin
      @(negedge clk);
      if (dout) d_hi++;
      if (pix_ready) r_hi++;
      if (!busy) b_lo++;
      if (frame_done) begin
        fd_cnt++;
        if (fd_pos < 0) fd_pos = i;
      end
    end
    check_int("latch_dout_high", d_hi, 0);
    check_int("latch_ready_high", r_hi, 0);
    check_int("latch_busy_low", b_lo, 0);
    check_int("latch_frame_done_count", fd_cnt, 1);
    check_int("latch_frame_done_pos", fd_pos, TRST-1);
    @(negedge clk);
    check_int("post_latch_busy", int'(busy), 0);
    check_int("post_latch_frame_done", int'(frame_done), 0);
    check_int("post_latch_ready", int'(pix_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{data: 24'hFFFFFF, last: 1'b0, gap: 0,   ones: 24};
    vec[1] = '{data: 24'h000000, last: 1'b0, gap: 0,   ones: 0};
    vec[2] = '{data: 24'h0F0F0F, last: 1'b1, gap: 0,   ones: 12};
    vec[3] = '{data: 24'h123456, last: 1'b0, gap: 0,   ones: 9};
    vec[4] = '{data: 24'h800001, last: 1'b0, gap: 100, ones: 2};

    rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rst_dout", int'(dout), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_ready", int'(pix_ready), 0);
    check_int("rst_frame_done", int'(frame_done), 0);
    check_int("rst_underrun", int'(underrun), 0);

    // Single last pixel; the next pixel is held valid through SHIFT and LATCH
    rst_n = 1'b1; pix_data = 24'hA50000; pix_last = 1'b1; pix_valid = 1'b1;
    #1;
    check_int("idle_ready", int'(pix_ready), 1);
    check_pixel(24'hA50000, 1'b1, 4, 1'b1, vec[0].data, vec[0].last);
    check_latch();

    for (int i = 0; i < 5; i++) begin
      logic nxt, b2b;
      logic [23:0] nd;
      logic nl;
      int ng;
      nxt = (i + 1 < 5);
      nd = '0; nl = 1'b0; ng = 0;
      if (nxt) begin
        nd = vec[i+1].data; nl = vec[i+1].last; ng = vec[i+1].gap;
      end
      b2b = nxt && !vec[i].last && (ng == 0);
      check_pixel(vec[i].data, vec[i].last, vec[i].ones, b2b, nd, nl);
      if (vec[i].last) begin
        check_latch();
        if (nxt) begin
          pix_data = nd; pix_last = nl; pix_valid = 1'b1;
        end
      end else if (nxt && !b2b) begin
        int g_err = 0;
        for (int g = 0; g < ng; g++) begin
          @(negedge clk);
          if (dout || !pix_ready || !busy || underrun || frame_done) g_err++;
          if (g == ng-1) begin
            pix_data = nd; pix_last = nl; pix_valid = 1'b1;
          end
        end
        check_int("gap_output_errs", g_err, 0);
      end
    end

    // Starved mid-frame: valid never returns after a non-last pixel
    begin
      int u_cnt = 0, u_pos = -1, b_lo = 0, d_hi = 0, r_lo = 0, fd = 0;
      for (int i = 0; i < TRST + 50; i++) begin
        @(negedge clk);
        if (underrun) begin
          u_cnt++;
          if (u_pos < 0) u_pos = i;
        end
        if (!busy) b_lo++;
        if (dout) d_hi++;
        if (!pix_ready) r_lo++;
        if (frame_done) fd++;
      end
`ifdef WS_UNDERRUN_EN
      check_int("starve_underrun_count", u_cnt, 1);
      check_int("starve_underrun_pos", u_pos, TRST-1);
      check_int("starve_busy_low", b_lo, 50);
`else
      check_int("starve_underrun_count", u_cnt, 0);
      check_int("starve_busy_low", b_lo, 0);
`endif
      check_int("starve_dout_high", d_hi, 0);
      check_int("starve_ready_low", r_lo, 0);
      check_int("starve_frame_done", fd, 0);
    end

    // Reset one cycle in the middle of bit 10
    pix_data = 24'hC3C3C3; pix_last = 1'b1; pix_valid = 1'b1;
    #1;
    check_int("rstseq_pre_ready", int'(pix_ready), 1);
    for (int n = 0; n <= 13*TBIT + 5; n++) begin
      @(negedge clk);
      if (n == 0) pix_valid = 1'b0;
    end
    check_int("rstseq_bit10_dout", int'(dout), 1);
    rst_n = 1'b0;
    #1;
    check_int("rstseq_ready_in_reset", int'(pix_ready), 0);
    @(negedge clk);
    check_int("rstseq_dout", int'(dout), 0);
    check_int("rstseq_busy", int'(busy), 0);
    check_int("rstseq_ready", int'(pix_ready), 0);
    check_int("rstseq_frame_done", int'(frame_done), 0);
    rst_n = 1'b1; pix_data = 24'h5A5A5A; pix_last = 1'b0; pix_valid = 1'b1;
    #1;
    check_int("rstseq_post_ready", int'(pix_ready), 1);
    check_pixel(24'h5A5A5A, 1'b0, 12, 1'b0, 24'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
